keypad_scanner: RTL and testbench
=================================

# keypad_scanner

Scan controller for the 4x4 matrix keypad. It drives one column at a time, synchronizes and debounces the row inputs, and locks onto a single pressed key. It reports each press as a one-cycle `key_valid` pulse with a 4-bit hex `key_code`. The block sits between the keypad pins and the display/entry logic, and is the only driver of the keypad columns.

## Interface
Parameters:
- `SCAN_CYCLES`, default 1000: column dwell time in clocks; must be ≥ 4.
- `DEBOUNCE_CYCLES`, default 20000: number of consecutive stable clocks required for press and release; must be ≥ 2.
- `REPEAT_DELAY`, default 500000: clocks from press to the first auto-repeat. Only used with `KEYPAD_AUTOREPEAT_EN`.
- `REPEAT_PERIOD`, default 100000: clocks between auto-repeats. Only used with `KEYPAD_AUTOREPEAT_EN`.

Ports:
- `clk` input 1: system clock. One clock domain only.
- `reset` input 1: asynchronous, active-high reset.
- `rows` input 4: raw row lines, active-high, asynchronous to `clk`.
- `cols` output 4: column drive, one-hot, active-high.
- `key_code` output 4: hex value of the last accepted key.
- `key_valid` output 1: one-cycle pulse per accepted press (and per repeat).
- `key_held` output 1: high while a key is locked.

## Operation
- `rows` passes through a 2-flop synchronizer; all logic below uses the synchronized value `rows_s`.
- Key map, indexed by row then column bit 0..3:
  - row0: 1, 2, 3, C
  - row1: 4, 5, 6, D
  - row2: 7, 8, 9, E
  - row3: A, 0, B, F
- **SCAN**
  - `cols` rotates 0001→0010→0100→1000→0001, one step every `SCAN_CYCLES` clocks.
  - `rows_s` is sampled only on the last dwell cycle (dwell count = `SCAN_CYCLES`-1).
  - If exactly one bit of `rows_s` is set, capture `cols`/`rows_s` and go to DEBOUNCE with `cols` frozen.
  - If zero or more than one bit is set, advance to the next column.
- **DEBOUNCE**
  - Counter increments each cycle that `rows_s` equals the captured row.
  - Any mismatch returns to SCAN, with `cols` advancing to the next column. No pulse is issued.
  - When the counter reaches `DEBOUNCE_CYCLES`-1 with a match, go to HELD. `key_code` loads the mapped value and `key_valid` pulses.
- **HELD**
  - `cols` stays frozen.
  - Other keys, including extra rows in the same column, are ignored.
  - When the captured row bit of `rows_s` drops to 0, go to RELEASE.
- **RELEASE**
  - Counter increments each cycle the captured row bit is 0.
  - If the bit returns to 1, go back to HELD. No new pulse is issued.
  - At `DEBOUNCE_CYCLES`-1, go to SCAN and advance to the next column.
- `key_held` is 1 in HELD and RELEASE, and 0 otherwise.
- `key_code` holds its value until the next accepted press.
- All counters are sized with `$clog2` of the largest parameter they compare against. Counters never wrap; they clear on every state entry.

## Timing
- Reset values: `cols`=0001, `key_code`=0, `key_valid`=0, `key_held`=0, state SCAN, all counters 0, synchronizer flops 0.
- Reset asserted mid-operation returns the block to these values immediately. Any in-progress press is discarded without a pulse.
- Press latency: `key_valid` is high in the first HELD cycle, which is exactly `DEBOUNCE_CYCLES` clocks after the SCAN capture cycle.
- `key_code` is valid in the same cycle as `key_valid` and stays stable afterwards.
- `key_valid` is never high on two consecutive cycles.
- A row change reaches `rows_s` 2 clocks after it occurs on `rows`.
- Worst-case detection delay from a stable press is 4×`SCAN_CYCLES` + 2 + `DEBOUNCE_CYCLES` clocks.

## Configuration
- `KEYPAD_AUTOREPEAT_EN` defined:
  - In HELD, a repeat counter starts on entry.
  - `key_valid` pulses again when the counter reaches `REPEAT_DELAY`, then every `REPEAT_PERIOD` clocks after that.
  - `key_code` is unchanged by repeats.
  - Entering RELEASE clears the repeat counter. Returning from RELEASE to HELD restarts it from 0.
- `KEYPAD_AUTOREPEAT_EN` not defined:
  - The repeat logic and the `REPEAT_*` parameters have no effect.
  - Exactly one pulse is issued per press.

## Structure
- Package `keypad_pkg` contains:
  - the state enum `kp_state_t` (SCAN, DEBOUNCE, HELD, RELEASE);
  - the column reset constant `COL_INIT` = 4'b0001;
  - the function `kp_map(cols, rows)` returning the 4-bit key code.
- Sub-module `sync_2ff`: a 4-bit two-flop synchronizer, clocked by `clk` and reset by `reset`.
- The FSM, counters and output registers are all in `keypad_scanner`.

## Test plan
All scenarios use `SCAN_CYCLES`=4 and `DEBOUNCE_CYCLES`=8.
- **Reset:** release `reset`, hold `rows`=0 for 20 clocks → `cols` cycles 0001, 0010, 0100, 1000, 0001 every 4 clocks; `key_valid`, `key_held` and `key_code` stay 0.
- **Clean press:** model key 6 (`rows`=0010 while `cols`=0100) for 40 clocks → exactly one `key_valid` pulse, 8 clocks after capture, with `key_code`=6. `cols` stays 0100 and `key_held`=1 until release is debounced.
- **Bouncy press:** key 9 pressed for 3 clocks, released for 2, then pressed for 3 → no pulse; scanning resumes with `cols`=1000.
- **Second key while held:** hold key 1, then also press key F → F is ignored. Release 1 and keep F → `key_held` falls; after re-scan, one pulse with `key_code`=F.
- **Multi-row in one column:** `rows`=0011 while `cols`=0001 → no capture, scan continues.
- **Reset mid-HELD:** assert `reset` during HELD → `cols`=0001 and `key_held`=0 asynchronously. With `KEYPAD_AUTOREPEAT_EN` defined and `REPEAT_DELAY`=16, `REPEAT_PERIOD`=8, holding key 0 gives pulses at 0, +16 and +24 clocks after the first pulse.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared types, constants and key-map helpers for the 4x4 keypad scanner.
package keypad_pkg;

  localparam int unsigned KP_LINES = 4;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2,
    RELEASE  = 2'd3
  } kp_state_t;

  localparam logic [KP_LINES-1:0] COL_INIT = 4'b0001;

  function automatic logic kp_onehot(input logic [KP_LINES-1:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

  function automatic logic [KP_LINES-1:0] kp_next_col(input logic [KP_LINES-1:0] c);
    return {c[KP_LINES-2:0], c[KP_LINES-1]};
  endfunction

  function automatic logic [1:0] kp_idx(input logic [KP_LINES-1:0] oh);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < KP_LINES; i++) begin
      if (oh[i]) idx = 2'(i);
    end
    return idx;
  endfunction

  // Index is {row, column}; layout matches the printed keypad legend.
  function automatic logic [3:0] kp_map(input logic [KP_LINES-1:0] cols,
                                        input logic [KP_LINES-1:0] rows);
    logic [3:0] code;
    case ({kp_idx(rows), kp_idx(cols)})
      4'h0: code = 4'h1;
      4'h1: code = 4'h2;
      4'h2: code = 4'h3;
      4'h3: code = 4'hC;
      4'h4: code = 4'h4;
      4'h5: code = 4'h5;
      4'h6: code = 4'h6;
      4'h7: code = 4'hD;
      4'h8: code = 4'h7;
      4'h9: code = 4'h8;
      4'hA: code = 4'h9;
      4'hB: code = 4'hE;
      4'hC: code = 4'hA;
      4'hD: code = 4'h0;
      4'hE: code = 4'hB;
      default: code = 4'hF;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for the asynchronous keypad row lines.
module sync_2ff
  import keypad_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic [KP_LINES-1:0] d,
  output logic [KP_LINES-1:0] q
);

  logic [KP_LINES-1:0] meta_q;
  logic [KP_LINES-1:0] sync_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scan / debounce / single-key lock controller.
// Optional auto-repeat while held: define KEYPAD_AUTOREPEAT_EN.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_CYCLES     = 1000,
  parameter int unsigned DEBOUNCE_CYCLES = 20000,
  parameter int unsigned REPEAT_DELAY    = 500000,
  parameter int unsigned REPEAT_PERIOD   = 100000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [KP_LINES-1:0] rows,
  output logic [KP_LINES-1:0] cols,
  output logic [3:0]          key_code,
  output logic                key_valid,
  output logic                key_held
);

  localparam int unsigned DW  = $clog2(SCAN_CYCLES);
  localparam int unsigned DBW = $clog2(DEBOUNCE_CYCLES);

  logic [KP_LINES-1:0] rows_s;

  kp_state_t           state_q, state_d;
  logic [KP_LINES-1:0] cols_q, cols_d;
  logic [KP_LINES-1:0] row_cap_q, row_cap_d;
  logic [DW-1:0]       dwell_q, dwell_d;
  logic [DBW-1:0]      cnt_q, cnt_d;
  logic [3:0]          key_code_q, key_code_d;
  logic                key_valid_q, key_valid_d;
  logic                key_held_q, key_held_d;
  logic                row_hit;

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RW      = $clog2(RPT_MAX);

  // rpt_ph_q: 0 while waiting for the first repeat, 1 once in the periodic phase.
  logic [RW-1:0] rpt_q, rpt_d;
  logic          rpt_ph_q, rpt_ph_d;
`else
  logic repeat_cfg_unused;
  assign repeat_cfg_unused = ^{REPEAT_DELAY, REPEAT_PERIOD};
`endif

  sync_2ff u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rows),
    .q     (rows_s)
  );

  assign row_hit = |(rows_s & row_cap_q);

  always_comb begin
    state_d     = state_q;
    cols_d      = cols_q;
    row_cap_d   = row_cap_q;
    dwell_d     = '0;
    cnt_d       = '0;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
    rpt_d       = '0;
    rpt_ph_d    = 1'b0;
`endif

    case (state_q)
      SCAN: begin
        if (dwell_q == DW'(SCAN_CYCLES - 1)) begin
          if (kp_onehot(rows_s)) begin
            state_d   = DEBOUNCE;
            row_cap_d = rows_s;
          end else begin
            cols_d = kp_next_col(cols_q);
          end
        end else begin
          dwell_d = dwell_q + DW'(1);
        end
      end

      DEBOUNCE: begin
        if (rows_s != row_cap_q) begin
          state_d = SCAN;
          cols_d  = kp_next_col(cols_q);
        end else if (cnt_q == DBW'(DEBOUNCE_CYCLES - 2)) begin
          state_d     = HELD;
          key_code_d  = kp_map(cols_q, row_cap_q);
          key_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q + DBW'(1);
        end
      end

      HELD: begin
        if (!row_hit) begin
          state_d = RELEASE;
        end else begin
`ifdef KEYPAD_AUTOREPEAT_EN
          rpt_d    = rpt_q + RW'(1);
          rpt_ph_d = rpt_ph_q;
          if ((!rpt_ph_q && rpt_q == RW'(REPEAT_DELAY - 1)) ||
              ( rpt_ph_q && rpt_q == RW'(REPEAT_PERIOD - 1))) begin
            key_valid_d = 1'b1;
            rpt_d       = '0;
            rpt_ph_d    = 1'b1;
          end
`endif
        end
      end

      RELEASE: begin
        if (row_hit) begin
          state_d = HELD;
        end else if (cnt_q == DBW'(DEBOUNCE_CYCLES - 2)) begin
          state_d = SCAN;
          cols_d  = kp_next_col(cols_q);
        end else begin
          cnt_d = cnt_q + DBW'(1);
        end
      end

      default: state_d = SCAN;
    endcase

    key_held_d = (state_d == HELD) || (state_d == RELEASE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= SCAN;
      cols_q      <= COL_INIT;
      row_cap_q   <= '0;
      dwell_q     <= '0;
      cnt_q       <= '0;
      key_code_q  <= '0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cols_q      <= cols_d;
      row_cap_q   <= row_cap_d;
      dwell_q     <= dwell_d;
      cnt_q       <= cnt_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
    end
  end

`ifdef KEYPAD_AUTOREPEAT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rpt_q    <= '0;
      rpt_ph_q <= 1'b0;
    end else begin
      rpt_q    <= rpt_d;
      rpt_ph_q <= rpt_ph_d;
    end
  end
`endif

  assign cols      = cols_q;
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with SCAN_CYCLES=4, DEBOUNCE_CYCLES=8.
module tb_keypad_scanner;

  logic        clk;
  logic        reset;
  logic [3:0]  rows;
  logic [3:0]  cols;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;

  // Pressed keys, index = row*4 + column.
  logic [15:0] pressed;

  int n_checks;
  int n_errors;
  int ecnt;
  int npulse;
  int back_to_back;
  logic prev_valid;

  keypad_scanner #(
    .SCAN_CYCLES     (4),
    .DEBOUNCE_CYCLES (8),
    .REPEAT_DELAY    (16),
    .REPEAT_PERIOD   (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rows      (rows),
    .cols      (cols),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Passive switch matrix: a row reads high when a pressed key sits in a driven column.
  always_comb begin
    rows = '0;
    for (int r = 0; r < 4; r++) rows[r] = |(pressed[r*4 +: 4] & cols);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic reset_dut();
    reset = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset        = 1'b0;
    ecnt         = 0;
    npulse       = 0;
    prev_valid   = 1'b0;
  endtask

  // Advance to 1ns after edge n (counted from reset release), logging pulses.
  task automatic step_to(input int n);
    while (ecnt < n) begin
      @(posedge clk);
      #1;
      ecnt++;
      if (key_valid) begin
        npulse++;
        if (prev_valid) back_to_back++;
      end
      prev_valid = key_valid;
    end
  endtask

  initial begin
    logic [3:0] exp_c;
    n_checks     = 0;
    n_errors     = 0;
    back_to_back = 0;
    pressed      = '0;
    reset        = 1'b1;

    // Idle rotation after reset.
    reset_dut();
    for (int k = 0; k < 20; k++) begin
      step_to(k);
      exp_c = 4'(1 << ((k / 4) % 4));
      check_eq("idle_cols", 32'(cols), 32'(exp_c));
      check_eq("idle_outs", 32'({key_valid, key_held, key_code}), 32'h0);
    end

    // Clean press of key 6.
    pressed = 16'(1 << 6);
    reset_dut();
    step_to(18);
    check_eq("k6_pre_valid", 32'(key_valid), 32'd0);
    check_eq("k6_pre_held", 32'(key_held), 32'd0);
    step_to(19);
    check_eq("k6_valid", 32'(key_valid), 32'd1);
    check_eq("k6_code", 32'(key_code), 32'h6);
    check_eq("k6_held", 32'(key_held), 32'd1);
    check_eq("k6_cols", 32'(cols), 32'b0100);
    step_to(20);
    check_eq("k6_one_cycle", 32'(key_valid), 32'd0);
    step_to(40);
    pressed = '0;
    step_to(49);
    check_eq("k6_rel_held", 32'(key_held), 32'd1);
    check_eq("k6_rel_cols", 32'(cols), 32'b0100);
    step_to(50);
    check_eq("k6_done_held", 32'(key_held), 32'd0);
    check_eq("k6_done_cols", 32'(cols), 32'b1000);
    check_eq("k6_code_kept", 32'(key_code), 32'h6);
    check_eq("k6_pulses", 32'(npulse), 32'd1);

    // Bouncy press of key 9 during debounce.
    pressed = '0;
    reset_dut();
    step_to(9);
    pressed = 16'(1 << 10);
    step_to(12);
    pressed = '0;
    step_to(13);
    check_eq("k9_frozen", 32'(cols), 32'b0100);
    step_to(14);
    pressed = 16'(1 << 10);
    step_to(15);
    check_eq("k9_resume", 32'(cols), 32'b1000);
    check_eq("k9_held", 32'(key_held), 32'd0);
    step_to(17);
    pressed = '0;
    step_to(40);
    check_eq("k9_pulses", 32'(npulse), 32'd0);

    // Key 1 held, key F added then 1 released.
    pressed = 16'(1 << 0);
    reset_dut();
    step_to(11);
    check_eq("k1_valid", 32'(key_valid), 32'd1);
    check_eq("k1_code", 32'(key_code), 32'h1);
    step_to(12);
    pressed = pressed | 16'(1 << 15);
    step_to(20);
    check_eq("k1f_held", 32'(key_held), 32'd1);
    check_eq("k1f_cols", 32'(cols), 32'b0001);
    check_eq("k1f_code", 32'(key_code), 32'h1);
    pressed = 16'(1 << 15);
    step_to(29);
    check_eq("k1_rel_held", 32'(key_held), 32'd1);
    step_to(30);
    check_eq("k1_rel_done", 32'(key_held), 32'd0);
    check_eq("k1_rel_cols", 32'(cols), 32'b0010);
    step_to(48);
    check_eq("kf_pre_valid", 32'(key_valid), 32'd0);
    step_to(49);
    check_eq("kf_valid", 32'(key_valid), 32'd1);
    check_eq("kf_code", 32'(key_code), 32'hF);
    check_eq("kf_cols", 32'(cols), 32'b1000);
    check_eq("k1f_pulses", 32'(npulse), 32'd2);

    // Two rows in column 0 are never captured.
    pressed = 16'((1 << 0) | (1 << 4));
    reset_dut();
    step_to(4);
    check_eq("multi_cols4", 32'(cols), 32'b0010);
    step_to(20);
    check_eq("multi_cols20", 32'(cols), 32'b0010);
    check_eq("multi_held", 32'(key_held), 32'd0);
    check_eq("multi_pulses", 32'(npulse), 32'd0);

    // Key 0 held, optional repeats, then asynchronous reset.
    pressed = 16'(1 << 13);
    reset_dut();
    step_to(15);
    check_eq("k0_valid", 32'(key_valid), 32'd1);
    check_eq("k0_code", 32'(key_code), 32'h0);
    check_eq("k0_cols", 32'(cols), 32'b0010);
`ifdef KEYPAD_AUTOREPEAT_EN
    step_to(30);
    check_eq("rpt_pre", 32'(key_valid), 32'd0);
    step_to(31);
    check_eq("rpt_first", 32'(key_valid), 32'd1);
    step_to(38);
    check_eq("rpt_gap", 32'(key_valid), 32'd0);
    step_to(39);
    check_eq("rpt_second", 32'(key_valid), 32'd1);
    step_to(42);
    check_eq("k0_pulses", 32'(npulse), 32'd3);
`else
    step_to(42);
    check_eq("k0_pulses", 32'(npulse), 32'd1);
`endif
    check_eq("k0_held", 32'(key_held), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check_eq("arst_cols", 32'(cols), 32'b0001);
    check_eq("arst_held", 32'(key_held), 32'd0);
    check_eq("arst_valid", 32'(key_valid), 32'd0);
    check_eq("arst_code", 32'(key_code), 32'h0);
    pressed = '0;
    @(posedge clk);
    #1;
    reset = 1'b0;

    check_eq("no_back_to_back", 32'(back_to_back), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
